// File: rtl/mp64_extmem_arb.sv
// Two-port round-robin arbiter for the external-memory PHY port.
// Grants one whole burst at a time and steers write/read beats to the owning master.
module mp64_extmem_arb #(
   parameter int ADDR_W  = 64,
   parameter int DATA_W  = 64,
   parameter int BURST_W = 8,
   parameter int TIMEOUT = 1024
) (
   input  logic               sys_clk,
   input  logic               sys_rst_n,
   input  logic               m0_req,
   input  logic [ADDR_W-1:0]  m0_addr,
   input  logic               m0_wen,
   input  logic [DATA_W-1:0]  m0_wdata,
   input  logic [BURST_W-1:0] m0_burst_len,
   output logic               m0_ready,
   output logic [DATA_W-1:0]  m0_rdata,
   output logic               m0_rvalid,
   output logic               m0_err,
   input  logic               m1_req,
   input  logic [ADDR_W-1:0]  m1_addr,
   input  logic               m1_wen,
   input  logic [DATA_W-1:0]  m1_wdata,
   input  logic [BURST_W-1:0] m1_burst_len,
   output logic               m1_ready,
   output logic [DATA_W-1:0]  m1_rdata,
   output logic               m1_rvalid,
   output logic               m1_err,
   output logic               phy_req,
   output logic [ADDR_W-1:0]  phy_addr,
   output logic               phy_wen,
   output logic [DATA_W-1:0]  phy_wdata,
   output logic [BURST_W-1:0] phy_burst_len,
   input  logic [DATA_W-1:0]  phy_rdata,
   input  logic               phy_rvalid,
   input  logic               phy_ready,
   output logic               busy
);

   localparam int TMO_W = $clog2(TIMEOUT);
   localparam logic [TMO_W-1:0]   TMO_LAST = TMO_W'(TIMEOUT - 1);
   localparam logic [TMO_W-1:0]   TMO_ONE  = TMO_W'(1);
   localparam logic [BURST_W:0]   CNT_ONE  = (BURST_W + 1)'(1);

   typedef enum logic [1:0] {IDLE, WRITE, RCMD, RDATA} state_t;

   state_t             state_reg, state_next;
   logic               owner_reg, owner_next;
   logic               last_owner_reg, last_owner_next;
   logic [BURST_W:0]   beat_cnt_reg, beat_cnt_next;
   logic [TMO_W-1:0]   tmo_cnt_reg, tmo_cnt_next;
   logic               grant;
   logic               owned;

   logic [1:0]         req_vec;
   logic [1:0]         wen_vec;
   logic [1:0]         ready_vec;
   logic [1:0]         rvalid_vec;
   logic [1:0]         err_vec;
   logic [ADDR_W-1:0]  addr_arr  [2];
   logic [DATA_W-1:0]  wdata_arr [2];
   logic [BURST_W-1:0] len_arr   [2];
   logic [BURST_W:0]   eff_len   [2];

   assign req_vec      = {m1_req, m0_req};
   assign wen_vec      = {m1_wen, m0_wen};
   assign addr_arr[0]  = m0_addr;
   assign addr_arr[1]  = m1_addr;
   assign wdata_arr[0] = m0_wdata;
   assign wdata_arr[1] = m1_wdata;
   assign len_arr[0]   = m0_burst_len;
   assign len_arr[1]   = m1_burst_len;

   // A zero length field still moves one beat.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_len
         assign eff_len[gi] = (len_arr[gi] == '0) ? CNT_ONE : {1'b0, len_arr[gi]};
      end
   endgenerate

   always_ff @(posedge sys_clk) begin
      if (!sys_rst_n) begin
         state_reg      <= IDLE;
         owner_reg      <= 1'b0;
         last_owner_reg <= 1'b1;
         beat_cnt_reg   <= '0;
         tmo_cnt_reg    <= '0;
      end else begin
         state_reg      <= state_next;
         owner_reg      <= owner_next;
         last_owner_reg <= last_owner_next;
         beat_cnt_reg   <= beat_cnt_next;
         tmo_cnt_reg    <= tmo_cnt_next;
      end
   end

   always_comb begin
      state_next      = state_reg;
      owner_next      = owner_reg;
      last_owner_next = last_owner_reg;
      beat_cnt_next   = beat_cnt_reg;
      tmo_cnt_next    = tmo_cnt_reg;
      grant           = 1'b0;
      phy_req         = 1'b0;
      ready_vec       = 2'b00;
      rvalid_vec      = 2'b00;
      err_vec         = 2'b00;
      case (state_reg)
         IDLE: begin
            if (req_vec != 2'b00) begin
               // On a tie the port that did not win last time goes next.
               grant           = (req_vec == 2'b11) ? ~last_owner_reg : req_vec[1];
               owner_next      = grant;
               last_owner_next = grant;
               beat_cnt_next   = eff_len[grant];
               tmo_cnt_next    = '0;
               state_next      = wen_vec[grant] ? WRITE : RCMD;
            end
         end
         WRITE: begin
            phy_req = 1'b1;
            if (phy_ready) begin
               ready_vec[owner_reg] = 1'b1;
               beat_cnt_next        = beat_cnt_reg - CNT_ONE;
               if (beat_cnt_reg <= CNT_ONE)
                  state_next = IDLE;
            end
         end
         RCMD: begin
            phy_req = 1'b1;
            if (phy_ready) begin
               ready_vec[owner_reg] = 1'b1;
               beat_cnt_next        = eff_len[owner_reg];
               tmo_cnt_next         = '0;
               state_next           = RDATA;
            end
         end
         RDATA: begin
            if (phy_rvalid) begin
               rvalid_vec[owner_reg] = 1'b1;
               beat_cnt_next         = beat_cnt_reg - CNT_ONE;
               tmo_cnt_next          = '0;
               if (beat_cnt_reg <= CNT_ONE)
                  state_next = IDLE;
            end else if (tmo_cnt_reg == TMO_LAST) begin
               err_vec[owner_reg] = 1'b1;
               state_next         = IDLE;
            end else begin
               tmo_cnt_next = tmo_cnt_reg + TMO_ONE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   assign owned         = (state_reg != IDLE);
   assign busy          = owned;
   assign phy_addr      = owned ? addr_arr[owner_reg] : '0;
   assign phy_wen       = owned ? wen_vec[owner_reg] : 1'b0;
   assign phy_wdata     = owned ? wdata_arr[owner_reg] : '0;
   assign phy_burst_len = owned ? eff_len[owner_reg][BURST_W-1:0] : '0;

   assign m0_ready  = ready_vec[0];
   assign m1_ready  = ready_vec[1];
   assign m0_rvalid = rvalid_vec[0];
   assign m1_rvalid = rvalid_vec[1];
   assign m0_err    = err_vec[0];
   assign m1_err    = err_vec[1];
   assign m0_rdata  = phy_rdata;
   assign m1_rdata  = phy_rdata;

endmodule

// File: tb/tb_mp64_extmem_arb.sv
// Directed bench for mp64_extmem_arb: per-port ready/rvalid/err events are
// predicted into a queue as stimulus is driven and matched as the DUT raises them.
module tb_mp64_extmem_arb;
   localparam int AW  = 64;
   localparam int DW  = 64;
   localparam int BW  = 8;
   localparam int TMO = 16;

   localparam logic [1:0] K_RDY = 2'd0;
   localparam logic [1:0] K_RV  = 2'd1;
   localparam logic [1:0] K_ERR = 2'd2;

   typedef struct packed {
      logic          port;
      logic [1:0]    kind;
      logic [63:0]   data;
   } ev_t;

   logic          sys_clk = 1'b0;
   logic          sys_rst_n;
   logic          m0_req, m0_wen, m0_ready, m0_rvalid, m0_err;
   logic [AW-1:0] m0_addr;
   logic [DW-1:0] m0_wdata, m0_rdata;
   logic [BW-1:0] m0_burst_len;
   logic          m1_req, m1_wen, m1_ready, m1_rvalid, m1_err;
   logic [AW-1:0] m1_addr;
   logic [DW-1:0] m1_wdata, m1_rdata;
   logic [BW-1:0] m1_burst_len;
   logic          phy_req, phy_wen, phy_rvalid, phy_ready, busy;
   logic [AW-1:0] phy_addr;
   logic [DW-1:0] phy_wdata, phy_rdata;
   logic [BW-1:0] phy_burst_len;

   int  vectors     = 0;
   int  miscompares = 0;
   ev_t exp_q[$];

   always #5 sys_clk = ~sys_clk;

   mp64_extmem_arb #(.ADDR_W(AW), .DATA_W(DW), .BURST_W(BW), .TIMEOUT(TMO)) dut (
      .sys_clk(sys_clk), .sys_rst_n(sys_rst_n),
      .m0_req(m0_req), .m0_addr(m0_addr), .m0_wen(m0_wen), .m0_wdata(m0_wdata),
      .m0_burst_len(m0_burst_len), .m0_ready(m0_ready), .m0_rdata(m0_rdata),
      .m0_rvalid(m0_rvalid), .m0_err(m0_err),
      .m1_req(m1_req), .m1_addr(m1_addr), .m1_wen(m1_wen), .m1_wdata(m1_wdata),
      .m1_burst_len(m1_burst_len), .m1_ready(m1_ready), .m1_rdata(m1_rdata),
      .m1_rvalid(m1_rvalid), .m1_err(m1_err),
      .phy_req(phy_req), .phy_addr(phy_addr), .phy_wen(phy_wen), .phy_wdata(phy_wdata),
      .phy_burst_len(phy_burst_len), .phy_rdata(phy_rdata), .phy_rvalid(phy_rvalid),
      .phy_ready(phy_ready), .busy(busy)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic push(input logic port, input logic [1:0] kind, input logic [63:0] data);
      ev_t e;
      e.port = port;
      e.kind = kind;
      e.data = data;
      exp_q.push_back(e);
   endtask

   // An event with nothing queued is compared against an impossible kind so it always counts.
   task automatic observe(input string tag, input logic port, input logic [1:0] kind,
                          input logic [63:0] data);
      ev_t got, want;
      got.port = port;
      got.kind = kind;
      got.data = data;
      want = '1;
      if (exp_q.size() != 0)
         want = exp_q.pop_front();
      vectors++;
      assert (got === want) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, got, want);
      end
   endtask

   always @(negedge sys_clk) begin
      if (m0_ready)  observe("m0_ready",  1'b0, K_RDY, 64'h0);
      if (m0_rvalid) observe("m0_rvalid", 1'b0, K_RV,  m0_rdata);
      if (m0_err)    observe("m0_err",    1'b0, K_ERR, 64'h0);
      if (m1_ready)  observe("m1_ready",  1'b1, K_RDY, 64'h0);
      if (m1_rvalid) observe("m1_rvalid", 1'b1, K_RV,  m1_rdata);
      if (m1_err)    observe("m1_err",    1'b1, K_ERR, 64'h0);
   end

   task automatic cyc();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic mid();
      @(negedge sys_clk);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_phy_req"},   phy_req,       0);
      chk({tag, "_phy_addr"},  phy_addr,      0);
      chk({tag, "_phy_wen"},   phy_wen,       0);
      chk({tag, "_phy_wdata"}, phy_wdata,     0);
      chk({tag, "_phy_len"},   phy_burst_len, 0);
      chk({tag, "_busy"},      busy,          0);
      chk({tag, "_outs"}, {m0_ready, m0_rvalid, m0_err, m1_ready, m1_rvalid, m1_err}, 0);
   endtask

   initial begin
      logic [63:0] wbeat [4];
      bit          pat [6];
      int          k;
      logic        o;

      wbeat[0] = 64'h1111_0000_AAAA_0001; wbeat[1] = 64'h2222_0000_BBBB_0002;
      wbeat[2] = 64'h3333_0000_CCCC_0003; wbeat[3] = 64'h4444_0000_DDDD_0004;
      pat[0] = 1; pat[1] = 0; pat[2] = 1; pat[3] = 1; pat[4] = 0; pat[5] = 1;

      sys_rst_n = 0;
      m0_req = 0; m0_addr = '0; m0_wen = 0; m0_wdata = '0; m0_burst_len = '0;
      m1_req = 0; m1_addr = '0; m1_wen = 0; m1_wdata = '0; m1_burst_len = '0;
      phy_rdata = 64'h55; phy_rvalid = 0; phy_ready = 0;

      // Reset state
      cyc(); cyc(); mid();
      chk_idle("reset");
      chk("reset_m0_rdata", m0_rdata, 64'h55);
      chk("reset_m1_rdata", m1_rdata, 64'h55);

      // Port 0 single read with PHY wait states
      cyc();
      sys_rst_n = 1; m0_req = 1; m0_addr = 64'h1000; m0_wen = 0; m0_burst_len = 8'd1;
      mid(); chk("t1_pre_busy", busy, 0);
      cyc(); mid();
      chk("t1_phy_req", phy_req, 1); chk("t1_phy_addr", phy_addr, 64'h1000);
      chk("t1_phy_wen", phy_wen, 0); chk("t1_phy_len", phy_burst_len, 1);
      chk("t1_busy", busy, 1);
      cyc(); mid(); chk("t1_wait_req", phy_req, 1);
      cyc(); phy_ready = 1; push(1'b0, K_RDY, 64'h0); mid();
      cyc(); phy_ready = 0; m0_req = 0; mid();
      chk("t1_rdata_phy_req", phy_req, 0); chk("t1_rdata_busy", busy, 1);
      cyc(); mid();
      cyc(); phy_rvalid = 1; phy_rdata = 64'hDEADBEEF; push(1'b0, K_RV, 64'hDEADBEEF); mid();
      chk("t1_m0_rdata", m0_rdata, 64'hDEADBEEF);
      cyc(); phy_rvalid = 0; mid();
      chk_idle("t1_done");

      // Port 1 write, len 4, PHY ready toggling
      cyc();
      m1_req = 1; m1_wen = 1; m1_addr = 64'h2000; m1_burst_len = 8'd4; m1_wdata = wbeat[0];
      mid();
      cyc();
      k = 0;
      for (int i = 0; i < 6; i++) begin
         phy_ready = pat[i];
         if (pat[i]) push(1'b1, K_RDY, 64'h0);
         mid();
         chk("t2_phy_req", phy_req, 1);
         chk("t2_phy_wdata", phy_wdata, wbeat[k]);
         chk("t2_phy_len", phy_burst_len, 4);
         cyc();
         if (pat[i]) begin
            k++;
            if (k < 4) m1_wdata = wbeat[k];
         end
      end
      phy_ready = 0; m1_req = 0; m1_wen = 0;
      mid();
      chk_idle("t2_done");

      // Both ports requesting from reset: grants alternate 0,1,0,1
      cyc();
      sys_rst_n = 0;
      m0_req = 1; m0_addr = 64'hA0; m0_wen = 0; m0_burst_len = 8'd2;
      m1_req = 1; m1_addr = 64'hB0; m1_wen = 0; m1_burst_len = 8'd2;
      mid(); chk_idle("t3_rst");
      cyc(); sys_rst_n = 1; mid(); chk("t3_idle_busy", busy, 0);
      for (int t = 0; t < 4; t++) begin
         o = t[0];
         cyc(); phy_ready = 1; push(o, K_RDY, 64'h0); mid();
         chk("t3_grant_addr", phy_addr, o ? 64'hB0 : 64'hA0);
         cyc(); phy_ready = 0; phy_rvalid = 1; phy_rdata = 64'hC00 + 64'(t * 16);
         push(o, K_RV, 64'hC00 + 64'(t * 16)); mid();
         cyc(); phy_rdata = 64'hC01 + 64'(t * 16);
         push(o, K_RV, 64'hC01 + 64'(t * 16)); mid();
         cyc(); phy_rvalid = 0;
         if (t == 3) begin m0_req = 0; m1_req = 0; end
         mid(); chk("t3_gap_busy", busy, 0);
      end

      // Read timeout: 2 of 3 beats, then silence, then a late beat
      cyc(); m1_req = 1; m1_addr = 64'h3000; m1_wen = 0; m1_burst_len = 8'd3; mid();
      cyc(); phy_ready = 1; push(1'b1, K_RDY, 64'h0); mid();
      cyc(); phy_ready = 0; m1_req = 0; phy_rvalid = 1; phy_rdata = 64'hE1;
      push(1'b1, K_RV, 64'hE1); mid();
      cyc(); phy_rdata = 64'hE2; push(1'b1, K_RV, 64'hE2); mid();
      for (int j = 1; j <= TMO; j++) begin
         cyc(); phy_rvalid = 0;
         if (j == TMO) push(1'b1, K_ERR, 64'h0);
         mid(); chk("t4_err_timing", m1_err, (j == TMO) ? 64'h1 : 64'h0);
      end
      cyc(); phy_rvalid = 1; phy_rdata = 64'hE3; mid();
      chk("t4_late_rvalid", m1_rvalid, 0); chk("t4_late_busy", busy, 0);
      cyc(); phy_rvalid = 0;

      // Reset in the middle of a port 0 read, then a normal port 1 read
      m0_req = 1; m0_addr = 64'h4000; m0_wen = 0; m0_burst_len = 8'd8; mid();
      cyc(); phy_ready = 1; push(1'b0, K_RDY, 64'h0); mid();
      cyc(); phy_ready = 0; m0_req = 0;
      for (int b = 0; b < 3; b++) begin
         if (b > 0) cyc();
         phy_rvalid = 1; phy_rdata = 64'h400 + 64'(b);
         push(1'b0, K_RV, 64'h400 + 64'(b)); mid();
      end
      cyc(); phy_rvalid = 0; sys_rst_n = 0; mid(); chk("t5_pre_rst_busy", busy, 1);
      cyc(); sys_rst_n = 1; phy_rvalid = 1; phy_rdata = 64'h403; mid();
      chk_idle("t5_after_rst");
      cyc(); phy_rdata = 64'h404;
      m1_req = 1; m1_addr = 64'h5000; m1_wen = 0; m1_burst_len = 8'd1; mid();
      chk("t5_stale_drop", m0_rvalid, 0);
      cyc(); phy_rvalid = 0; phy_ready = 1; push(1'b1, K_RDY, 64'h0); mid();
      chk("t5_m1_addr", phy_addr, 64'h5000);
      cyc(); phy_ready = 0; m1_req = 0; phy_rvalid = 1; phy_rdata = 64'hF1;
      push(1'b1, K_RV, 64'hF1); mid();
      cyc(); phy_rvalid = 0; mid();
      chk_idle("t5_done");

      // Zero-length write moves exactly one beat
      cyc(); m0_req = 1; m0_addr = 64'h6000; m0_wen = 1; m0_burst_len = 8'd0; m0_wdata = 64'h77;
      mid();
      cyc(); phy_ready = 1; push(1'b0, K_RDY, 64'h0); mid();
      chk("t6_phy_len", phy_burst_len, 1); chk("t6_phy_wdata", phy_wdata, 64'h77);
      chk("t6_phy_wen", phy_wen, 1);
      cyc(); m0_req = 0; m0_wen = 0; mid();
      chk_idle("t6_done");
      cyc(); phy_ready = 0; mid();

      chk("scoreboard_empty", 64'(exp_q.size()), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
